// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle MULT/DIV sequencer that borrows the core ALU.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_e;

  localparam logic [7:0] ALU_ADD  = 8'h04;
  localparam logic [7:0] ALU_SUB  = 8'h0C;
  localparam logic [7:0] ALU_IDLE = 8'h00;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  // Per-operation control captured when a start is accepted.
  typedef struct packed {
    logic is_div;
    logic sa;
    logic sb;
    logic negq;
    logic negr;
  } req_t;

  function automatic req_t decode(input op_e op, input logic a_msb, input logic b_msb);
    req_t r;
    r.is_div = op[1];
    r.sa     = op[0] & a_msb;
    r.sb     = op[0] & b_msb;
    r.negq   = r.sa ^ r.sb;
    // Remainder takes the dividend's sign; the product high word takes the product's sign.
    r.negr   = r.is_div ? r.sa : (r.sa ^ r.sb);
    return r;
  endfunction

endpackage

// File: rtl/muldiv_cy.sv
// Recovers the ALU's missing bit-32 carry (add) or borrow (sub) from the MSBs of x, y and the sum.
module muldiv_cy (
  input  logic x,
  input  logic y,
  input  logic s,
  input  logic sub,
  output logic cy
);

  always_comb begin
    if (sub) cy = (~x & y) | ((~x | y) & s);
    else     cy = (x & y) | ((x | y) & ~s);
  end

endmodule

// File: rtl/muldiv_seq.sv
// Fixed-latency shift-add multiplier / restoring divider; every add, subtract and negate
// goes through the shared combinational ALU while busy.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [7:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_sh,
  input  logic [WIDTH-1:0] alu_y
);

  if (WIDTH != 32) begin : g_width_chk
    $error("muldiv_seq: only WIDTH=32 is supported");
  end

  state_e           state, state_nxt;
  req_t             req;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [CNT_W-1:0] cnt;
  logic             lo_nz;
  logic             cy;
  logic [WIDTH-1:0] shifted;

  assign shifted = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);
  assign alu_sh  = '0;

  muldiv_cy u_cy (
    .x   (alu_a[WIDTH-1]),
    .y   (alu_b[WIDTH-1]),
    .s   (alu_y[WIDTH-1]),
    .sub (req.is_div),
    .cy  (cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_ctrl  = ALU_IDLE;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_NEG_A;
      S_NEG_A: begin
        alu_ctrl  = ALU_SUB;
        alu_b     = a_reg;
        state_nxt = S_NEG_B;
      end
      S_NEG_B: begin
        alu_ctrl  = ALU_SUB;
        alu_b     = b_reg;
        state_nxt = S_ITER;
      end
      S_ITER: begin
        alu_b = b_reg;
        if (req.is_div) begin
          alu_ctrl = ALU_SUB;
          alu_a    = shifted;
        end else begin
          alu_ctrl = ALU_ADD;
          alu_a    = hi;
        end
        if (cnt == '0) state_nxt = S_FIX_LO;
      end
      S_FIX_LO: begin
        alu_ctrl  = ALU_SUB;
        alu_b     = lo;
        state_nxt = S_FIX_HI;
      end
      S_FIX_HI: begin
        // All-ones minus hi is ~hi: the 64-bit negate only carries into hi when lo was zero.
        alu_ctrl  = ALU_SUB;
        alu_a     = (!req.is_div && lo_nz) ? '1 : '0;
        alu_b     = hi;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = start ? S_NEG_A : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      req   <= '0;
      cnt   <= '0;
      lo_nz <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            req   <= decode(op_e'(op), a[WIDTH-1], b[WIDTH-1]);
          end
        end
        S_NEG_A: if (req.sa) a_reg <= alu_y;
        S_NEG_B: begin
          if (req.sb) b_reg <= alu_y;
          hi  <= '0;
          lo  <= a_reg;
          cnt <= CNT_W'(ITER_COUNT - 1);
        end
        S_ITER: begin
          cnt <= cnt - 1'b1;
          if (req.is_div) begin
            // A set bit shifted out of hi means the partial remainder already exceeds |b|.
            if (hi[WIDTH-1] | ~cy) begin
              hi <= alu_y;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= shifted;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else if (lo[0]) begin
            hi <= {cy, alu_y[WIDTH-1:1]};
            lo <= {alu_y[0], lo[WIDTH-1:1]};
          end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
          end
        end
        S_FIX_LO: begin
          lo_nz <= |lo;
          if (req.negq) lo <= alu_y;
        end
        S_FIX_HI: if (req.negr) hi <= alu_y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized + directed bench for muldiv_seq against a transaction-level arithmetic model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b, alu_y;
  logic [7:0]  alu_ctrl;
  logic [4:0]  alu_sh;

  logic cx = 1'b0, cy_in = 1'b0, cs = 1'b0, csub = 1'b0, cy_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for the core ALU: only add and subtract are exercised.
  assign alu_y = (alu_ctrl == 8'h04) ? alu_a + alu_b :
                 (alu_ctrl == 8'h0C) ? alu_a - alu_b : 32'h0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_sh(alu_sh), .alu_y(alu_y)
  );

  muldiv_cy u_cy (.x(cx), .y(cy_in), .s(cs), .sub(csub), .cy(cy_out));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {hi, lo} from plain arithmetic on the operation's definition.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mx, my, q, r;
    logic        sx, sy;
    if (o == 2'd0) return {32'h0, x} * {32'h0, y};
    if (o == 2'd1) return {{32{x[31]}}, x} * {{32{y[31]}}, y};
    sx = o[0] & x[31];
    sy = o[0] & y[31];
    mx = sx ? -x : x;
    my = sy ? -y : y;
    if (my == 0) begin
      q = 32'hFFFF_FFFF;
      r = mx;
    end else begin
      q = mx / my;
      r = mx % my;
    end
    if (sx ^ sy) q = -q;
    if (sx) r = -r;
    return {r, q};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Model: cyc counts cycles since the accepted start (0 = idle, 37 = done).
  int          cyc = 0;
  logic [1:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [63:0] pend = '0, expv = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= 0;
      expv <= '0;
    end else if (start && (cyc == 0 || cyc == 37)) begin
      cyc  <= 1;
      m_op <= op;
      m_a  <= a;
      m_b  <= b;
      pend <= ref_result(op, a, b);
    end else if (cyc == 36) begin
      cyc  <= 37;
      expv <= pend;
    end else if (cyc == 37) begin
      cyc <= 0;
    end else if (cyc != 0) begin
      cyc <= cyc + 1;
    end
  end

  logic [31:0] ma, mb;

  initial forever begin
    @(negedge clk);
    ma = (m_op[0] && m_a[31]) ? -m_a : m_a;
    mb = (m_op[0] && m_b[31]) ? -m_b : m_b;
    chk("busy", 64'(busy), 64'(cyc >= 1 && cyc <= 36));
    chk("done", 64'(done), 64'(cyc == 37));
    chk("alu_sh", 64'(alu_sh), 64'h0);
    if (cyc == 0 || cyc == 37) begin
      chk("hi", 64'(hi), 64'(expv[63:32]));
      chk("lo", 64'(lo), 64'(expv[31:0]));
      chk("idle_ctrl", 64'(alu_ctrl), 64'h0);
      chk("idle_a", 64'(alu_a), 64'h0);
      chk("idle_b", 64'(alu_b), 64'h0);
    end else begin
      chk("alu_ctrl", 64'(alu_ctrl),
          64'((cyc >= 3 && cyc <= 34 && !m_op[1]) ? 8'h04 : 8'h0C));
      if (cyc == 1) begin
        chk("neg_a_opa", 64'(alu_a), 64'h0);
        chk("neg_a_opb", 64'(alu_b), 64'(m_a));
      end
      if (cyc == 2) begin
        chk("neg_b_opa", 64'(alu_a), 64'h0);
        chk("neg_b_opb", 64'(alu_b), 64'(m_b));
      end
      if (cyc >= 3 && cyc <= 34) chk("iter_opb", 64'(alu_b), 64'(mb));
      if (cyc == 3) chk("iter0_opa", 64'(alu_a), 64'(m_op[1] ? {31'h0, ma[31]} : 32'h0));
      if (cyc == 35) chk("fix_lo_opa", 64'(alu_a), 64'h0);
      if (cyc == 36 && m_op[1]) chk("fix_hi_opa_div", 64'(alu_a), 64'h0);
      if (cyc == 36 && m_op == 2'd1)
        chk("fix_hi_opa_mult", 64'(alu_a), 64'((pend[31:0] != 0) ? 32'hFFFF_FFFF : 32'h0));
    end
  end

  // noise: 0 quiet, 1 random start pulses while busy, 2 single pulse in cycle 10.
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int noise, input bit lit, input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        start = (noise == 1) ? ($urandom_range(0, 3) == 0) : (noise == 2) ? (n == 10) : 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
      end
    end while (!done && n < 60);
    start = 1'b0;
    chk("latency", 64'(n), 64'd37);
    if (lit) begin
      chk("hi_lit", 64'(hi), 64'(eh));
      chk("lo_lit", 64'(lo), 64'(el));
    end
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      logic [31:0] x, y;
      logic [32:0] s33;
      logic        sub;
      x = pick(); y = pick(); sub = 1'($urandom_range(0, 1));
      s33 = sub ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
      cx = x[31]; cy_in = y[31]; cs = s33[31]; csub = sub;
      #1;
      chk("cy_unit", 64'(cy_out), 64'(s33[32]));
    end

    run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    run(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run(2'd1, 32'h0,         32'hFFFF_FFFB, 0, 1'b1, 32'h0,         32'h0);
    run(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run(2'd2, 32'd64,        32'd7,         2, 1'b1, 32'd1,         32'd9);
    run(2'd2, 32'd5,         32'd0,         0, 1'b1, 32'd5,         32'hFFFF_FFFF);
    run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         32'h8000_0000);

    // start held through DONE launches the next op immediately
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd5;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 60);
    chk("b2b_lat1", 64'(n), 64'd37);
    chk("b2b_lo1", 64'(lo), 64'd15);
    op = 2'd2; a = 32'd64; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin @(negedge clk); n++; end
    chk("b2b_lat2", 64'(n), 64'd37);
    chk("b2b_hi2", 64'(hi), 64'd1);
    chk("b2b_lo2", 64'(lo), 64'd9);

    // asynchronous reset in the middle of the iteration phase
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = $urandom; b = $urandom;
    n = 0;
    do begin @(negedge clk); n++; start = 1'b0; end while (n < 17);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    chk("arst_hi", 64'(hi), 64'h0);
    chk("arst_lo", 64'(lo), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2'd0, 32'd3, 32'd4, 0, 1'b1, 32'd0, 32'd12);

    for (int i = 0; i < 40; i++) run(2'($urandom), pick(), pick(), 1, 1'b0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared combinational 32-bit ALU for every add, subtract and negate.
- Sits beside the core ALU and fills the unused multiply slot in its result mux.
- Holds HI/LO result registers.
- Drives the ALU control, operand and shift-amount inputs only while busy; the core's ALU-source mux selects this block when busy=1.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; the block raises an elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch request; accepted only in IDLE or DONE
- op  in  2  0 MULTU, 1 MULT, 2 DIVU, 3 DIV
- a  in  32  multiplicand / dividend, captured on accepted start
- b  in  32  multiplier / divisor, captured on accepted start
- busy  out  1  high in NEG_A..FIX_HI
- done  out  1  one-cycle pulse, high in the DONE state
- hi  out  32  product[63:32] or remainder
- lo  out  32  product[31:0] or quotient
- alu_ctrl  out  8  ALU control; only ADD=8'h04 or SUB=8'h0C, driven 8'h00 when idle
- alu_a  out  32  ALU operand A; 0 when idle
- alu_b  out  32  ALU operand B; 0 when idle
- alu_sh  out  5  constant 0
- alu_y  in  32  combinational ALU result, same cycle

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - hi, lo, all internal registers = 0; busy = 0, done = 0.
  - Reset mid-operation aborts the operation; hi/lo clear.
- States and sequence: IDLE -> NEG_A -> NEG_B -> ITER(x32, 5-bit counter 31..0) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
  - From DONE, start=1 goes straight to NEG_A.
  - start is ignored while busy.
- Latency: start accepted at edge 0 -> done=1 during cycle 37, with hi/lo final.
  - hi/lo hold the last result until the next accepted start.
- Signedness:
  - sgn = op[0]; sa = sgn & a[31]; sb = sgn & b[31].
  - Captured at start: negq = sa^sb; negr = sa for DIV, negr = sa^sb for MULT.
- NEG_A: ALU SUB, A=0, B=a_reg; if sa, a_reg <= alu_y.
- NEG_B: same operation on b_reg with sb.
- After NEG_B both operands are unsigned magnitudes.
  - 0x80000000 stays 0x80000000 and is treated as 2^31.
- Multiply iteration:
  - Init: hi=0, lo=|a|.
  - ALU ADD, A=hi, B=|b|.
  - c = carry(hi[31], |b|[31], alu_y[31]), where carry = (x&y)|((x|y)&~s).
  - If lo[0]: {hi,lo} <= {c, alu_y, lo[31:1]}; else {hi,lo} <= {1'b0, hi, lo[31:1]}.
- Divide iteration (restoring):
  - Init: hi=0, lo=|a|.
  - r32 = hi[31]; shifted = {hi[30:0], lo[31]}.
  - ALU SUB, A=shifted, B=|b|.
  - borrow = (~x&y)|((~x|y)&s).
  - If r32 | ~borrow: hi <= alu_y, lo <= {lo[30:0],1}; else hi <= shifted, lo <= {lo[30:0],0}.
- FIX_LO:
  - Latch lo_nz = (lo != 0).
  - ALU SUB, A=0, B=lo; if negq, lo <= alu_y.
- FIX_HI:
  - MULT: ALU SUB, A = (lo_nz ? 32'hFFFFFFFF : 0), B = hi. This completes the 64-bit two's-complement negate.
  - DIV: ALU SUB, A=0, B=hi.
  - hi <= alu_y if negr.
- The ALU bus is driven with the stated ops even when the result is discarded. This gives fixed latency; there is no early exit.
- Divide by zero:
  - DIVU yields lo=FFFFFFFF, hi=a.
  - DIV applies the normal sign fixups to those magnitudes.
- DIV 0x80000000 / FFFFFFFF yields lo=0x80000000, hi=0 (wrap).
- MULTU/MULT results are exact 64-bit.

Decomposition:
- muldiv_pkg holds:
  - op encodings: MULTU, MULT, DIVU, DIV
  - state enum
  - ALU control constants: ALU_ADD=8'h04, ALU_SUB=8'h0C, ALU_IDLE=8'h00
  - ITER_COUNT=32
- One sub-module, muldiv_cy: purely combinational carry/borrow recovery from (x31, y31, s31, sub). It is the only logic that reconstructs bit 32, which the ALU does not output. Unit-test it separately.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF -> done in cycle 37, hi=FFFFFFFE, lo=00000001; busy high cycles 1-36.
- MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; MULT a=0 b=-5 -> hi=0, lo=0 (lo_nz path).
- DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=64 b=7 -> lo=9, hi=1.
- DIVU a=5 b=0 -> lo=FFFFFFFF, hi=5; DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
- Handshake: start pulsed again in cycle 10 is ignored; start held in DONE launches back-to-back and the second done lands 37 cycles later; alu_ctrl=00 and alu_a/alu_b=0 whenever idle.
- rst_n asserted at ITER cycle 15 (asynchronously, mid-clock) -> busy, done, hi, lo go to 0 immediately; a fresh MULTU 3x4 after release -> lo=12, hi=0.
